// File: rtl/branch_resolve_unit.sv
// Branch resolution for ID: decodes the conditional branches, registers the outcome
// and mispredict flag for EX, and maintains a 2-bit saturating BHT plus statistics.
module branch_resolve_unit #(
  parameter int         DATA_W    = 32,
  parameter int         PC_W      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic [31:0]       id_instr,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_pred_taken,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic              res_link,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc_stat(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + STAT_W'(1);
  endfunction

  logic signed [DATA_W-1:0] rs1_s, rs2_s;
  logic [5:0]       op;
  logic [4:0]       rt;
  logic             rs1_neg, rs1_zero;
  logic             is_branch, is_link, cond, resolve;
  logic [IDX_W-1:0] lookup_idx, update_idx;
  logic [1:0]       bht [BHT_DEPTH];

  logic             vld_p1, taken_p1, mispred_p1, link_p1;
  logic [STAT_W-1:0] br_cnt_p1, mis_cnt_p1;

  // Instruction fields and pc bits that play no part in resolution
  logic unused_bits;
  assign unused_bits = ^{id_instr[25:21], id_instr[15:0],
                         if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                         id_pc[PC_W-1:IDX_W+2], id_pc[1:0]};

  assign op       = id_instr[31:26];
  assign rt       = id_instr[20:16];
  assign rs1_s    = signed'(rs1);
  assign rs2_s    = signed'(rs2);
  assign rs1_neg  = rs1_s[DATA_W-1];
  assign rs1_zero = (rs1_s == '0);

  always_comb begin
    is_branch = 1'b0;
    is_link   = 1'b0;
    cond      = 1'b0;
    case (op)
      OP_BEQ:  begin is_branch = 1'b1; cond = (rs1_s == rs2_s);    end
      OP_BNE:  begin is_branch = 1'b1; cond = (rs1_s != rs2_s);    end
      OP_BLEZ: begin is_branch = 1'b1; cond = rs1_neg | rs1_zero;  end
      OP_BGTZ: begin is_branch = 1'b1; cond = ~rs1_neg & ~rs1_zero; end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   begin is_branch = 1'b1; cond = rs1_neg;  end
          RT_BGEZ:   begin is_branch = 1'b1; cond = ~rs1_neg; end
          RT_BLTZAL: begin is_branch = 1'b1; is_link = 1'b1; cond = rs1_neg;  end
          RT_BGEZAL: begin is_branch = 1'b1; is_link = 1'b1; cond = ~rs1_neg; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign resolve    = id_valid & is_branch & ~id_stall;
  assign lookup_idx = if_pc[IDX_W+1:2];
  assign update_idx = id_pc[IDX_W+1:2];

  // Prediction reads the array directly, so a same-cycle update is not visible yet
  assign if_pred_taken = bht[lookup_idx][1];

  // ---- ID -> EX boundary (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      taken_p1   <= 1'b0;
      mispred_p1 <= 1'b0;
      link_p1    <= 1'b0;
      br_cnt_p1  <= '0;
      mis_cnt_p1 <= '0;
    end else begin
      vld_p1     <= resolve;
      taken_p1   <= resolve & cond;
      mispred_p1 <= resolve & (cond != id_pred_taken);
      link_p1    <= resolve & is_link;
      if (resolve) begin
        br_cnt_p1 <= sat_inc_stat(br_cnt_p1);
        if (cond != id_pred_taken) mis_cnt_p1 <= sat_inc_stat(mis_cnt_p1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
    end else if (resolve) begin
      bht[update_idx] <= cond ? sat_inc2(bht[update_idx]) : sat_dec2(bht[update_idx]);
    end
  end

  assign res_valid        = vld_p1;
  assign res_taken        = taken_p1;
  assign res_mispredict   = mispred_p1;
  assign res_link         = link_p1;
  assign stat_branches    = br_cnt_p1;
  assign stat_mispredicts = mis_cnt_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: decode outcomes, link, BHT saturation,
// stall/reset interaction, statistics saturation (STAT_W=4) and read-before-update.
module tb_branch_resolve_unit;
  localparam int STAT_W = 4;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic              clk, rst;
  logic [31:0]       if_pc;
  logic              if_pred_taken;
  logic              id_valid, id_stall;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc;
  logic              id_pred_taken;
  logic [31:0]       rs1, rs2;
  logic              res_valid, res_taken, res_mispredict, res_link;
  logic [STAT_W-1:0] stat_branches, stat_mispredicts;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(
    .DATA_W(32), .PC_W(32), .BHT_DEPTH(16), .CNT_INIT(2'b01), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .id_valid(id_valid), .id_stall(id_stall), .id_instr(id_instr),
    .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .rs1(rs1), .rs2(rs2),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_link(res_link),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_valid = 1'b0;
    id_stall = 1'b0;
  endtask

  task automatic set_br(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic pred);
    id_instr      = {op, 5'd0, rt, 16'h0000};
    rs1           = a;
    rs2           = b;
    id_pc         = pc;
    id_pred_taken = pred;
    id_valid      = 1'b1;
  endtask

  task automatic apply_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({res_valid, res_taken, res_mispredict, res_link} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_res got=%b exp=0000", {res_valid, res_taken, res_mispredict, res_link});
    end
    checks++;
    if ({stat_branches, stat_mispredicts} !== 8'h00) begin
      failures++;
      $display("FAIL reset_stats got=%h/%h exp=0/0", stat_branches, stat_mispredicts);
    end
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4);
      #1;
      checks++;
      if (if_pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred idx=%0d got=%b exp=0", i, if_pred_taken);
      end
    end
  endtask

  task automatic test_beq;
    set_br(OP_BEQ, 5'd0, 32'h5, 32'h5, 32'h40, 1'b0);
    tick();
    idle();
    checks++;
    if ({res_valid, res_taken, res_mispredict, res_link} !== 4'b1110) begin
      failures++;
      $display("FAIL beq_res got=%b exp=1110", {res_valid, res_taken, res_mispredict, res_link});
    end
    checks++;
    if ({stat_branches, stat_mispredicts} !== 8'h11) begin
      failures++;
      $display("FAIL beq_stats got=%h/%h exp=1/1", stat_branches, stat_mispredicts);
    end
    if_pc = 32'h40;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL beq_pred got=%b exp=1", if_pred_taken);
    end
    tick();
    checks++;
    if ({res_valid, res_taken, res_mispredict, res_link} !== 4'b0000) begin
      failures++;
      $display("FAIL beq_clear got=%b exp=0000", {res_valid, res_taken, res_mispredict, res_link});
    end
  endtask

  logic [5:0]  c_op  [15];
  logic [4:0]  c_rt  [15];
  logic [31:0] c_a   [15];
  logic [31:0] c_b   [15];
  logic        c_exp [15];

  task automatic test_conditions;
    c_op  = '{OP_BLEZ, OP_BLEZ, OP_BLEZ, OP_BGTZ, OP_BGTZ, OP_BGTZ,
              OP_REGIMM, OP_REGIMM, OP_REGIMM, OP_REGIMM, OP_REGIMM, OP_REGIMM,
              OP_BEQ, OP_BNE, OP_BNE};
    c_rt  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
              5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0};
    c_a   = '{32'h0, 32'h1, 32'h8000_0000, 32'h0, 32'h1, 32'h8000_0000,
              32'h0, 32'h1, 32'h8000_0000, 32'h0, 32'h1, 32'h8000_0000,
              32'h5, 32'h5, 32'h7};
    c_b   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h6, 32'h6, 32'h7};
    c_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 15; i++) begin
      set_br(c_op[i], c_rt[i], c_a[i], c_b[i], 32'h104, 1'b0);
      tick();
      checks++;
      if ({res_valid, res_taken, res_mispredict, res_link} !== {1'b1, c_exp[i], c_exp[i], 1'b0}) begin
        failures++;
        $display("FAIL cond row=%0d op=%b rs1=%h got=%b exp=%b", i, c_op[i], c_a[i],
                 {res_valid, res_taken, res_mispredict, res_link}, {1'b1, c_exp[i], c_exp[i], 1'b0});
      end
    end
    idle();
  endtask

  task automatic test_link_and_nonbranch;
    set_br(OP_REGIMM, 5'b10000, 32'h1, 32'h0, 32'h104, 1'b1);
    tick();
    checks++;
    if ({res_valid, res_taken, res_mispredict, res_link} !== 4'b1011) begin
      failures++;
      $display("FAIL bltzal got=%b exp=1011", {res_valid, res_taken, res_mispredict, res_link});
    end
    set_br(OP_REGIMM, 5'b10001, 32'h0, 32'h0, 32'h104, 1'b1);
    tick();
    checks++;
    if ({res_valid, res_taken, res_mispredict, res_link} !== 4'b1101) begin
      failures++;
      $display("FAIL bgezal got=%b exp=1101", {res_valid, res_taken, res_mispredict, res_link});
    end
    // Bring entry 2 to 10 so any decrement would drop the prediction
    apply_reset();
    set_br(OP_BEQ, 5'd0, 32'h1, 32'h1, 32'h8, 1'b0);
    tick();
    set_br(OP_REGIMM, 5'b00010, 32'h0, 32'h0, 32'h8, 1'b1);
    tick();
    checks++;
    if ({res_valid, res_taken, res_mispredict, res_link} !== 4'b0000) begin
      failures++;
      $display("FAIL regimm_rt2 got=%b exp=0000", {res_valid, res_taken, res_mispredict, res_link});
    end
    set_br(6'b000000, 5'd0, 32'h3, 32'h3, 32'h8, 1'b1);
    tick();
    idle();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL nonbranch_op got=%b exp=0", res_valid);
    end
    if_pc = 32'h8;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL nonbranch_bht got=%b exp=1", if_pred_taken);
    end
    checks++;
    if (stat_branches !== 4'h1) begin
      failures++;
      $display("FAIL nonbranch_stats got=%h exp=1", stat_branches);
    end
  endtask

  logic sat_exp [10];

  task automatic test_bht_saturation;
    // 4 taken, 4 not-taken, then 2 taken: 10 11 11 11 | 10 01 00 00 | 01 10
    sat_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    if_pc = 32'h80;
    for (int i = 0; i < 10; i++) begin
      if (i < 4 || i >= 8) set_br(OP_BEQ, 5'd0, 32'h9, 32'h9, 32'h80, 1'b1);
      else                 set_br(OP_BNE, 5'd0, 32'h9, 32'h9, 32'h80, 1'b1);
      tick();
      checks++;
      if (if_pred_taken !== sat_exp[i]) begin
        failures++;
        $display("FAIL bht_sat step=%0d got=%b exp=%b", i, if_pred_taken, sat_exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_stall_and_reset_priority;
    apply_reset();
    id_stall = 1'b1;
    set_br(OP_BEQ, 5'd0, 32'h2, 32'h2, 32'h40, 1'b0);
    tick();
    idle();
    if_pc = 32'h40;
    #1;
    checks++;
    if ({res_valid, if_pred_taken, stat_branches, stat_mispredicts} !== 10'b0_0_0000_0000) begin
      failures++;
      $display("FAIL stall got=v%b p%b s%h/%h exp=v0 p0 s0/0", res_valid, if_pred_taken,
               stat_branches, stat_mispredicts);
    end
    set_br(OP_BEQ, 5'd0, 32'h2, 32'h2, 32'h40, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if ({res_valid, if_pred_taken, stat_branches, stat_mispredicts} !== 10'b0_0_0000_0000) begin
      failures++;
      $display("FAIL rst_with_resolve got=v%b p%b s%h/%h exp=v0 p0 s0/0", res_valid, if_pred_taken,
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_back_to_back_stats;
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      set_br(OP_BEQ, 5'd0, 32'h4, 32'h4, 32'h3C, 1'b0);
      tick();
      if (i == 15 || i == 16 || i == 17) begin
        checks++;
        if ({res_valid, res_mispredict, stat_branches, stat_mispredicts} !== 10'b1_1_1111_1111) begin
          failures++;
          $display("FAIL stat_sat n=%0d got=v%b m%b s%h/%h exp=v1 m1 sF/F", i, res_valid,
                   res_mispredict, stat_branches, stat_mispredicts);
        end
      end
    end
    idle();
    checks++;
    if ({stat_branches, stat_mispredicts} !== 8'h80 + 8'h7F) begin
      failures++;
      $display("FAIL stat_hold got=%h/%h exp=F/F", stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_same_cycle_read_update;
    apply_reset();
    set_br(OP_BEQ, 5'd0, 32'h1, 32'h1, 32'hC, 1'b0);
    tick();
    set_br(OP_BNE, 5'd0, 32'h1, 32'h1, 32'hC, 1'b1);
    if_pc = 32'hC;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL same_idx_old got=%b exp=1", if_pred_taken);
    end
    tick();
    idle();
    checks++;
    if (if_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL same_idx_new got=%b exp=0", if_pred_taken);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    id_valid = 1'b0;
    id_stall = 1'b0;
    id_instr = '0;
    id_pc = '0;
    id_pred_taken = 1'b0;
    rs1 = '0;
    rs2 = '0;
    tick();
    test_reset();
    test_beq();
    test_conditions();
    test_link_and_nonbranch();
    test_bht_saturation();
    test_stall_and_reset_priority();
    test_back_to_back_stats();
    test_same_cycle_read_update();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
